// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep sequencer and its neighbours.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SWEEP = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int PHASE_W_DEF = 32;
  localparam int DWELL_W_DEF = 16;

  localparam int unsigned F_CLK_HZ  = 27_000_000;
  // Increment for a ~30 kHz tone with a 32-bit accumulator at F_CLK_HZ
  localparam logic [31:0] INC_30KHZ = 32'd4772186;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Linear-chirp sequencer for the DDS/PWM sine generator; every frequency
// change lands on a PWM period boundary so duty cycles never glitch.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_start_inc,
  input  logic [PHASE_W-1:0] cfg_stop_inc,
  input  logic [PHASE_W-1:0] cfg_step_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  input  logic               pwm_wrap,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               dds_en,
  output logic               busy,
  output logic               done
);

  // state | meaning
  // IDLE  | no sweep; a finished single sweep keeps its stop tone running
  // ARM   | sweep requested, waiting for the next PWM boundary
  // SWEEP | stepping phase_inc toward stop, one step per dwell
  // STOP  | aborting, gating the generator off at the next boundary

  state_t state_q, state_d;

  logic [PHASE_W-1:0] cfg_start_q, cfg_stop_q, cfg_step_q;
  logic [DWELL_W-1:0] cfg_dwell_q;
  logic               cfg_repeat_q;

  // Snapshot taken at start so a config write during the sweep cannot leak in
  logic [PHASE_W-1:0] run_start_q, run_stop_q, run_step_q;
  logic [DWELL_W-1:0] run_dwell_q;
  logic               run_repeat_q;

  logic [DWELL_W-1:0] dwell_cnt, dwell_d;
  logic               at_stop_q, at_stop_d;
  logic [PHASE_W-1:0] phase_d;
  logic               en_d, done_d, busy_d, ready_d;
  logic               load_run;
  logic               cfg_fire;

  logic [PHASE_W:0]   next_sum;
  logic               step_end;

  assign cfg_fire = cfg_valid & cfg_ready;

  // Carry or reaching stop clamps to stop; the increment never wraps
  assign next_sum = {1'b0, phase_inc} + {1'b0, run_step_q};
  assign step_end = next_sum[PHASE_W]
                  | (next_sum[PHASE_W-1:0] >= run_stop_q)
                  | (run_step_q == '0);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_inc;
    en_d      = dds_en;
    done_d    = 1'b0;
    dwell_d   = dwell_cnt;
    at_stop_d = at_stop_q;
    load_run  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (abort) begin
          if (dds_en) state_d = STOP;
        end else if (start) begin
          state_d  = ARM;
          load_run = 1'b1;
        end
      end

      ARM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pwm_wrap) begin
          state_d   = SWEEP;
          phase_d   = run_start_q;
          en_d      = 1'b1;
          dwell_d   = run_dwell_q;
          at_stop_d = 1'b0;
        end
      end

      SWEEP: begin
        if (abort) begin
          state_d = STOP;
        end else if (pwm_wrap) begin
          if (dwell_cnt != '0) begin
            dwell_d = dwell_cnt - 1'b1;
          end else if (at_stop_q) begin
            at_stop_d = 1'b0;
            if (run_repeat_q) begin
              phase_d = run_start_q;
              dwell_d = run_dwell_q;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else if (step_end) begin
            phase_d   = run_stop_q;
            dwell_d   = run_dwell_q;
            at_stop_d = 1'b1;
          end else begin
            phase_d = next_sum[PHASE_W-1:0];
            dwell_d = run_dwell_q;
          end
        end
      end

      STOP: begin
        if (pwm_wrap) begin
          state_d   = IDLE;
          en_d      = 1'b0;
          phase_d   = '0;
          at_stop_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_inc    <= '0;
      dds_en       <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      cfg_ready    <= 1'b1;
      dwell_cnt    <= '0;
      at_stop_q    <= 1'b0;
      cfg_start_q  <= '0;
      cfg_stop_q   <= '0;
      cfg_step_q   <= '0;
      cfg_dwell_q  <= '0;
      cfg_repeat_q <= 1'b0;
      run_start_q  <= '0;
      run_stop_q   <= '0;
      run_step_q   <= '0;
      run_dwell_q  <= '0;
      run_repeat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_inc <= phase_d;
      dds_en    <= en_d;
      done      <= done_d;
      busy      <= busy_d;
      cfg_ready <= ready_d;
      dwell_cnt <= dwell_d;
      at_stop_q <= at_stop_d;

      if (cfg_fire) begin
        cfg_start_q  <= cfg_start_inc;
        cfg_stop_q   <= cfg_stop_inc;
        cfg_step_q   <= cfg_step_inc;
        cfg_dwell_q  <= cfg_dwell;
        cfg_repeat_q <= cfg_repeat;
      end

      // Reads the pre-handshake values, so a same-cycle cfg write applies next time
      if (load_run) begin
        run_start_q  <= cfg_start_q;
        run_stop_q   <= cfg_stop_q;
        run_step_q   <= cfg_step_q;
        run_dwell_q  <= cfg_dwell_q;
        run_repeat_q <= cfg_repeat_q;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: each PWM wrap pushes the expected
// registered response; a monitor pops and compares one cycle after the wrap.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int PW = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [PW-1:0] cfg_start_inc = '0;
  logic [PW-1:0] cfg_stop_inc = '0;
  logic [PW-1:0] cfg_step_inc = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          cfg_repeat = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          pwm_wrap = 1'b0;
  logic [PW-1:0] phase_inc;
  logic          dds_en;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.PHASE_W(PW), .DWELL_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_start_inc (cfg_start_inc),
    .cfg_stop_inc  (cfg_stop_inc),
    .cfg_step_inc  (cfg_step_inc),
    .cfg_dwell     (cfg_dwell),
    .cfg_repeat    (cfg_repeat),
    .start         (start),
    .abort         (abort),
    .pwm_wrap      (pwm_wrap),
    .phase_inc     (phase_inc),
    .dds_en        (dds_en),
    .busy          (busy),
    .done          (done)
  );

  typedef struct packed {
    logic [PW-1:0] ph;
    logic          en;
    logic          dn;
    logic          bz;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   wrap_idx = 0;
  logic wrap_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_seen <= 1'b0;
    else        wrap_seen <= pwm_wrap;
  end

  always @(negedge clk) begin
    if (wrap_seen) begin
      exp_t e;
      wrap_idx++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wrap%0d: response with no expectation queued (phase_inc %0h)", wrap_idx, phase_inc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("wrap%0d phase_inc", wrap_idx), phase_inc, e.ph);
        check($sformatf("wrap%0d dds_en", wrap_idx), dds_en, e.en);
        check($sformatf("wrap%0d done", wrap_idx), done, e.dn);
        check($sformatf("wrap%0d busy", wrap_idx), busy, e.bz);
      end
    end
  end

  task automatic wrap(input logic [PW-1:0] ph, input logic en, input logic dn,
                      input logic bz, input logic ab = 1'b0);
    exp_q.push_back({ph, en, dn, bz});
    @(negedge clk);
    pwm_wrap = 1'b1;
    abort    = ab;
    @(negedge clk);
    pwm_wrap = 1'b0;
    abort    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_cfg(input logic [PW-1:0] s, input logic [PW-1:0] t,
                        input logic [PW-1:0] st, input logic [DW-1:0] dw, input logic rp);
    @(negedge clk);
    cfg_valid     = 1'b1;
    cfg_start_inc = s;
    cfg_stop_inc  = t;
    cfg_step_inc  = st;
    cfg_dwell     = dw;
    cfg_repeat    = rp;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic run_basic();
    do_cfg(100, 400, 100, 1, 1'b0);
    pulse_start();
    check("busy after start", busy, 1);
    wrap(100, 1, 0, 1);
    wrap(100, 1, 0, 1);
    wrap(200, 1, 0, 1);
    wrap(200, 1, 0, 1);
    wrap(300, 1, 0, 1);
    wrap(300, 1, 0, 1);
    wrap(400, 1, 0, 1);
    wrap(400, 1, 0, 1);
    wrap(400, 1, 1, 0);
    wrap(400, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic glitch;

    #1 rst_n = 1'b0;
    #3;
    check("reset phase_inc", phase_inc, 0);
    check("reset dds_en", dds_en, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset cfg_ready", cfg_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single sweep, tone held afterwards
    run_basic();

    // Repeating sweep, then abort
    do_cfg(100, 400, 100, 1, 1'b1);
    pulse_start();
    wrap(100, 1, 0, 1);
    wrap(100, 1, 0, 1);
    wrap(200, 1, 0, 1);
    wrap(200, 1, 0, 1);
    wrap(300, 1, 0, 1);
    wrap(300, 1, 0, 1);
    wrap(400, 1, 0, 1);
    wrap(400, 1, 0, 1);
    wrap(100, 1, 0, 1);
    wrap(100, 1, 0, 1);
    pulse_abort();
    check("abort holds tone until boundary", dds_en, 1);
    check("busy in STOP", busy, 1);
    wrap(0, 0, 0, 0);

    // Overflow clamp
    do_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 0, 1'b0);
    pulse_start();
    wrap(32'hFFFF_FF00, 1, 0, 1);
    wrap(32'hFFFF_FFFF, 1, 0, 1);
    wrap(32'hFFFF_FFFF, 1, 1, 0);

    // Zero step jumps straight to stop
    do_cfg(100, 400, 0, 0, 1'b0);
    pulse_start();
    wrap(100, 1, 0, 1);
    wrap(400, 1, 0, 1);
    wrap(400, 1, 1, 0);
    pulse_abort();
    check("abort in IDLE with tone -> STOP", busy, 1);
    wrap(0, 0, 0, 0);

    // No boundary, no change
    do_cfg(100, 400, 100, 0, 1'b0);
    pulse_start();
    glitch = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dds_en !== 1'b0 || phase_inc !== '0) glitch = 1'b1;
    end
    check("outputs quiet without wrap", glitch, 0);
    exp_q.push_back({32'd100, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    pwm_wrap = 1'b1;
    #1 check("no update before wrap edge", dds_en, 0);
    @(negedge clk);
    pwm_wrap = 1'b0;
    repeat (2) @(negedge clk);

    // start / cfg while busy are ignored
    pulse_start();
    check("start while busy keeps phase", phase_inc, 100);
    @(negedge clk);
    cfg_valid    = 1'b1;
    cfg_step_inc = 50;
    #1 check("cfg_ready low while busy", cfg_ready, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    wrap(200, 1, 0, 1);

    // abort wins over a simultaneous step
    wrap(200, 1, 0, 1, 1'b1);
    wrap(0, 0, 0, 0);

    // Async reset mid-sweep
    do_cfg(100, 400, 100, 1, 1'b0);
    pulse_start();
    wrap(100, 1, 0, 1);
    wrap(100, 1, 0, 1);
    wrap(200, 1, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset phase_inc", phase_inc, 0);
    check("async reset dds_en", dds_en, 0);
    check("async reset busy", busy, 0);
    check("async reset cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_basic();

    repeat (4) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
